ledger_txn_arbiter: RTL and testbench

Serialises balance transactions from NUM_REQ ATM session controllers onto one shared single-port account ledger RAM. Grants requesters round-robin, performs a read-modify-write on the addressed account, checks funds and overflow, and returns the result with a one-cycle done pulse. It sits between the per-terminal ATM FSMs and the ledger memory, and is the only writer of that memory.

---
 rtl/ledger_txn_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_ledger_txn_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ledger_txn_arbiter.sv
// ledger_txn_arbiter
// Serialises balance transactions from NUM_REQ ATM sessions onto one shared
// single-port ledger RAM. Sessions are granted round-robin. Each grant runs a
// fixed IDLE -> RD -> EXEC -> RESP sequence: read the account, check funds or
// overflow, write back when legal, then pulse done to the granted session.
//
// Optional feature macro: LEDGER_ARB_LIMIT_EN enables the per-transaction
// withdraw limit WD_LIMIT (err 11). Without it, err 11 is never produced.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   req             one request bit per session
//   req_op          2 bits per session: 00 withdraw, 01 deposit, 10 inquiry, 11 illegal
//   req_acct        ACCT_W bits per session, account address
//   req_value       BAL_W bits per session, amount
//   done            one-hot completion pulse to the granted session
//   resp_balance    post-transaction balance (pre-transaction balance on error)
//   resp_err        00 ok, 01 insufficient funds, 10 overflow/illegal, 11 over limit
//   busy            high whenever a transaction is in flight
//   mem_addr        ledger address
//   mem_rd_en       ledger read strobe (data returns one cycle later)
//   mem_rdata       ledger read data
//   mem_wr_en       ledger write strobe
//   mem_wdata       ledger write data
module ledger_txn_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int BAL_W = 20,
  parameter int ACCT_W = 4,
  parameter logic [BAL_W-1:0] WD_LIMIT = 20'd5000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [2*NUM_REQ-1:0]       req_op,
  input  logic [ACCT_W*NUM_REQ-1:0]  req_acct,
  input  logic [BAL_W*NUM_REQ-1:0]   req_value,
  output logic [NUM_REQ-1:0]         done,
  output logic [BAL_W-1:0]           resp_balance,
  output logic [1:0]                 resp_err,
  output logic                       busy,
  output logic [ACCT_W-1:0]          mem_addr,
  output logic                       mem_rd_en,
  input  logic [BAL_W-1:0]           mem_rdata,
  output logic                       mem_wr_en,
  output logic [BAL_W-1:0]           mem_wdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    EXEC = 2'b10,
    RESP = 2'b11
  } state_t;

  state_t                state_r;
  logic [IDX_W-1:0]      rr_ptr_r;
  logic [IDX_W-1:0]      grant_r;
  logic [1:0]            op_r;
  logic [ACCT_W-1:0]     acct_r;
  logic [BAL_W-1:0]      value_r;
  logic                  rd_en_r;
  logic [NUM_REQ-1:0]    done_r;
  logic [BAL_W-1:0]      resp_balance_r;
  logic [1:0]            resp_err_r;

  logic [IDX_W-1:0]      pick_s;
  logic [IDX_W-1:0]      next_ptr_s;
  logic [BAL_W:0]        sum_s;
  logic [BAL_W-1:0]      new_bal_s;
  logic [1:0]            err_s;
  logic                  wr_s;
  logic                  over_limit_s;

  // First requesting session at or after ptr, wrapping modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] sel;
    logic             found;
    int unsigned      cand;
    sel   = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (!found && r[cand]) begin
        sel   = IDX_W'(cand);
        found = 1'b1;
      end else begin
        sel   = sel;
      end
    end
    return sel;
  endfunction

  // Round-robin selection and the pointer value following that grant.
  always_comb begin
    pick_s = rr_pick(req, rr_ptr_r);
    if (pick_s == IDX_W'(NUM_REQ - 1)) begin
      next_ptr_s = {IDX_W{1'b0}};
    end else begin
      next_ptr_s = pick_s + IDX_W'(1);
    end
  end

`ifdef LEDGER_ARB_LIMIT_EN
  assign over_limit_s = (value_r > WD_LIMIT);
`else
  // Limit check compiled out; the term is forced low.
  assign over_limit_s = 1'b0 & (value_r > WD_LIMIT);
`endif

  // Transaction result from the account balance returned by the ledger.
  always_comb begin
    sum_s     = {1'b0, mem_rdata} + {1'b0, value_r};
    new_bal_s = mem_rdata;
    err_s     = 2'b00;
    wr_s      = 1'b0;
    case (op_r)
      2'b00: begin
        // Limit takes precedence over the funds check.
        if (over_limit_s) begin
          err_s = 2'b11;
        end else if (value_r > mem_rdata) begin
          err_s = 2'b01;
        end else begin
          new_bal_s = mem_rdata - value_r;
          wr_s      = 1'b1;
        end
      end
      2'b01: begin
        if (sum_s[BAL_W]) begin
          err_s = 2'b10;
        end else begin
          new_bal_s = sum_s[BAL_W-1:0];
          wr_s      = 1'b1;
        end
      end
      2'b10: begin
        wr_s = 1'b0;
      end
      default: begin
        err_s = 2'b10;
      end
    endcase
  end

  // Transaction sequencer: grant, latch fields, read, execute, respond.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= IDLE;
      rr_ptr_r       <= {IDX_W{1'b0}};
      grant_r        <= {IDX_W{1'b0}};
      op_r           <= 2'b00;
      acct_r         <= {ACCT_W{1'b0}};
      value_r        <= {BAL_W{1'b0}};
      rd_en_r        <= 1'b0;
      done_r         <= {NUM_REQ{1'b0}};
      resp_balance_r <= {BAL_W{1'b0}};
      resp_err_r     <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          if (|req) begin
            grant_r  <= pick_s;
            op_r     <= req_op[int'(pick_s)*2 +: 2];
            acct_r   <= req_acct[int'(pick_s)*ACCT_W +: ACCT_W];
            value_r  <= req_value[int'(pick_s)*BAL_W +: BAL_W];
            rr_ptr_r <= next_ptr_s;
            rd_en_r  <= 1'b1;
            state_r  <= RD;
          end else begin
            state_r  <= IDLE;
          end
        end
        RD: begin
          rd_en_r <= 1'b0;
          state_r <= EXEC;
        end
        EXEC: begin
          done_r         <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_r;
          resp_balance_r <= new_bal_s;
          resp_err_r     <= err_s;
          state_r        <= RESP;
        end
        RESP: begin
          done_r  <= {NUM_REQ{1'b0}};
          state_r <= IDLE;
        end
        default: begin
          rd_en_r <= 1'b0;
          done_r  <= {NUM_REQ{1'b0}};
          state_r <= IDLE;
        end
      endcase
    end
  end

  // The write strobe depends on this cycle's read data, so it is qualified by
  // the registered EXEC state; reset drops it immediately.
  assign mem_wr_en    = (state_r == EXEC) && wr_s;
  assign mem_wdata    = mem_wr_en ? new_bal_s : {BAL_W{1'b0}};
  assign mem_addr     = acct_r;
  assign mem_rd_en    = rd_en_r;
  assign done         = done_r;
  assign resp_balance = resp_balance_r;
  assign resp_err     = resp_err_r;
  assign busy         = (state_r != IDLE);

endmodule

// File: tb/tb_ledger_txn_arbiter.sv
// Self-checking bench for ledger_txn_arbiter with a behavioural ledger RAM
// and a reference ledger model computed from the transaction rules.
module tb_ledger_txn_arbiter;

  localparam int NREQ = 4;
`ifdef LEDGER_ARB_LIMIT_EN
  localparam bit LIMIT_ON = 1'b1;
`else
  localparam bit LIMIT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  req_op;
  logic [15:0] req_acct;
  logic [79:0] req_value;
  logic [3:0]  done;
  logic [19:0] resp_balance;
  logic [1:0]  resp_err;
  logic        busy;
  logic [3:0]  mem_addr;
  logic        mem_rd_en;
  logic [19:0] mem_rdata;
  logic        mem_wr_en;
  logic [19:0] mem_wdata;

  // RAM model and preload port
  logic [19:0] ram [16];
  logic        pl_en;
  logic [3:0]  pl_addr;
  logic [19:0] pl_data;

  // Reference ledger and per-session field record
  logic [19:0] ref_mem [16];
  logic [1:0]  s_op   [NREQ];
  logic [3:0]  s_acct [NREQ];
  logic [19:0] s_val  [NREQ];
  int          exp_ord [8];
  int          rereq_sess;
  logic [1:0]  re_op;
  logic [3:0]  re_acct;
  logic [19:0] re_val;

  int compared = 0;
  int mismatched = 0;

  ledger_txn_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_acct(req_acct),
    .req_value(req_value), .done(done), .resp_balance(resp_balance),
    .resp_err(resp_err), .busy(busy), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_wr_en) ram[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transaction rules, computed arithmetically.
  function automatic void model_txn(input logic [1:0] op, input logic [19:0] bal,
                                    input logic [19:0] val, output logic [19:0] nb,
                                    output logic [1:0] err, output logic wr);
    longint b, v;
    b = longint'(bal);
    v = longint'(val);
    nb = bal; err = 2'd0; wr = 1'b0;
    case (op)
      2'd0: begin
        if (LIMIT_ON && v > 5000) err = 2'd3;
        else if (v > b) err = 2'd1;
        else begin nb = 20'(b - v); wr = 1'b1; end
      end
      2'd1: begin
        if (b + v > 64'd1048575) err = 2'd2;
        else begin nb = 20'(b + v); wr = 1'b1; end
      end
      2'd2: err = 2'd0;
      default: err = 2'd2;
    endcase
  endfunction

  task automatic set_sess(input int s, input logic [1:0] op, input logic [3:0] acct,
                          input logic [19:0] val);
    req_op[2*s +: 2]     = op;
    req_acct[4*s +: 4]   = acct;
    req_value[20*s +: 20] = val;
    s_op[s] = op; s_acct[s] = acct; s_val[s] = val;
  endtask

  task automatic preload(input logic [3:0] a, input logic [19:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // One transaction from an idle DUT, checked cycle by cycle.
  task automatic run_txn(input int s, input logic [1:0] op, input logic [3:0] acct,
                         input logic [19:0] val, input string tag);
    logic [19:0] nb;
    logic [1:0]  err;
    logic        wr;
    model_txn(op, ref_mem[acct], val, nb, err, wr);
    set_sess(s, op, acct, val);
    req[s] = 1'b1;
    @(posedge clk); #1;
    req[s] = 1'b0;
    set_sess(s, ~op, ~acct, ~val);
    check({tag, "_rd_busy"}, busy, 1);
    check({tag, "_rd_en"}, mem_rd_en, 1);
    check({tag, "_rd_addr"}, mem_addr, acct);
    @(posedge clk); #1;
    check({tag, "_wr_en"}, mem_wr_en, wr);
    if (wr) check({tag, "_wdata"}, mem_wdata, nb);
    check({tag, "_early_done"}, done, 0);
    @(posedge clk); #1;
    check({tag, "_done"}, done, 32'(4'b0001 << s));
    check({tag, "_bal"}, resp_balance, nb);
    check({tag, "_err"}, resp_err, err);
    if (wr) ref_mem[acct] = nb;
    @(posedge clk); #1;
    check({tag, "_idle_done"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_ledger"}, ram[acct], ref_mem[acct]);
  endtask

  // Serve n queued grants, checking order, spacing and results; ends in IDLE.
  task automatic collect(input int n, input string tag);
    int got, last, cyc, idx;
    logic [19:0] nb;
    logic [1:0]  err;
    logic        wr;
    got = 0; last = -1; cyc = 0;
    while (got < n && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      if (done != 4'b0000) begin
        idx = 0;
        for (int i = 0; i < NREQ; i++) if (done[i]) idx = i;
        check($sformatf("%s_onehot%0d", tag, got), 32'($onehot(done)), 1);
        check($sformatf("%s_order%0d", tag, got), idx, exp_ord[got]);
        if (last >= 0) check($sformatf("%s_spacing%0d", tag, got), cyc - last, 4);
        last = cyc;
        model_txn(s_op[idx], ref_mem[s_acct[idx]], s_val[idx], nb, err, wr);
        check($sformatf("%s_bal%0d", tag, got), resp_balance, nb);
        check($sformatf("%s_err%0d", tag, got), resp_err, err);
        if (wr) ref_mem[s_acct[idx]] = nb;
        req[idx] = 1'b0;
        if (idx == rereq_sess) begin
          set_sess(idx, re_op, re_acct, re_val);
          req[idx] = 1'b1;
          rereq_sess = -1;
        end
        got++;
      end
    end
    check({tag, "_served"}, got, n);
    @(posedge clk); #1;
    check({tag, "_end_busy"}, busy, 0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [3:0]  racct;
    logic [19:0] rval;
    int          rs;
    rst = 1'b0; req = 4'b0; req_op = 8'b0; req_acct = 16'b0; req_value = 80'b0;
    pl_en = 1'b0; pl_addr = 4'd0; pl_data = 20'd0; rereq_sess = -1;
    re_op = 2'd0; re_acct = 4'd0; re_val = 20'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", done, 0);
    check("rst_bal", resp_balance, 0);
    check("rst_err", resp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int a = 0; a < 16; a++) preload(4'(a), 20'($urandom_range(0, 20'hFFFFF)));
    preload(4'd3, 20'd1000);
    preload(4'd5, 20'd100);
    preload(4'd2, 20'hFFFF0);
    preload(4'd0, 20'd9000);
    preload(4'd7, 20'd500);
    preload(4'd9, 20'd200);
    preload(4'd4, 20'd10);

    // Directed cases
    run_txn(0, 2'd0, 4'd3, 20'd300, "wd300");
    check("wd300_ref", ref_mem[3], 20'd700);
    run_txn(1, 2'd0, 4'd5, 20'd101, "wd_short");
    run_txn(1, 2'd0, 4'd5, 20'd100, "wd_exact");
    check("wd_exact_ref", ref_mem[5], 20'd0);
    run_txn(2, 2'd1, 4'd2, 20'h20, "dep_ovf");
    run_txn(2, 2'd1, 4'd2, 20'h0F, "dep_max");
    check("dep_max_ref", ref_mem[2], 20'hFFFFF);
    run_txn(0, 2'd0, 4'd3, 20'd0, "wd_zero");
    run_txn(1, 2'd1, 4'd3, 20'd0, "dep_zero");
    run_txn(2, 2'd2, 4'd7, 20'd55, "inquiry");
    run_txn(1, 2'd3, 4'd7, 20'd55, "illegal");
    run_txn(3, 2'd0, 4'd0, 20'd6000, "wd_limit");

    // Round robin from rr_ptr 0, session 0 re-requests after its done
    set_sess(0, 2'd1, 4'd9, 20'd50);
    set_sess(1, 2'd0, 4'd9, 20'd30);
    set_sess(2, 2'd2, 4'd9, 20'd0);
    set_sess(3, 2'd1, 4'd4, 20'd5);
    rereq_sess = 0; re_op = 2'd0; re_acct = 4'd9; re_val = 20'd10;
    exp_ord[0] = 0; exp_ord[1] = 1; exp_ord[2] = 2; exp_ord[3] = 3; exp_ord[4] = 0;
    req = 4'b1111;
    collect(5, "rr");

    // Reset during EXEC of a deposit
    set_sess(2, 2'd1, 4'd7, 20'd123);
    req[2] = 1'b1;
    @(posedge clk); #1;
    req[2] = 1'b0;
    @(posedge clk); #1;
    check("rstx_wr_before", mem_wr_en, 1);
    rst = 1'b0;
    #1;
    check("rstx_wr_drop", mem_wr_en, 0);
    check("rstx_busy", busy, 0);
    check("rstx_rd_en", mem_rd_en, 0);
    @(posedge clk); #1;
    check("rstx_done", done, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstx_ledger", ram[7], ref_mem[7]);
    set_sess(1, 2'd2, 4'd7, 20'd0);
    set_sess(3, 2'd0, 4'd7, 20'd25);
    exp_ord[0] = 1; exp_ord[1] = 3;
    req = 4'b1010;
    collect(2, "post_rst");

    // Randomised single-session transactions
    for (int t = 0; t < 40; t++) begin
      rs    = int'($urandom_range(0, 3));
      rop   = 2'($urandom_range(0, 3));
      racct = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: rval = 20'($urandom_range(0, 50));
        1: rval = ref_mem[racct] + 20'($urandom_range(0, 2)) - 20'd1;
        2: rval = 20'($urandom_range(0, 20'hFFFFF));
        default: rval = 20'($urandom_range(4000, 7000));
      endcase
      run_txn(rs, rop, racct, rval, $sformatf("rnd%0d", t));
    end

    for (int a = 0; a < 16; a++) check($sformatf("final_ledger%0d", a), ram[a], ref_mem[a]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
